// File: rtl/nn_fixed_pkg.sv
// Shared Q17.15 fixed-point definitions and the backprop FSM state encoding.
package nn_fixed_pkg;

  localparam int WIDTH = 32;
  localparam int FRAC  = 15;
  localparam logic signed [WIDTH-1:0] ONE     = 32'sh0000_8000;
  localparam logic signed [WIDTH-1:0] MAX_POS = 32'sh7FFF_FFFF;
  localparam logic signed [WIDTH-1:0] MAX_NEG = 32'sh8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_FETCH,
    ST_MUL,
    ST_HOLD,
    ST_DONE
  } state_e;

  // Clamp a 33-bit intermediate back into the 32-bit signed range.
  function automatic logic signed [WIDTH-1:0] sat32(input logic signed [WIDTH:0] v);
    if (v[WIDTH] != v[WIDTH-1]) return v[WIDTH] ? MAX_NEG : MAX_POS;
    return v[WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fx_mul_sat.sv
// Q17.15 signed multiply: full 64-bit product, arithmetic shift by FRAC, saturate to 32 bits.
module fx_mul_sat
  import nn_fixed_pkg::*;
(
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] shifted;

  always_comb begin
    prod    = 64'(a) * 64'(b);
    shifted = prod >>> FRAC;
    // Result fits when the bits above the 32-bit sign position all agree.
    if ((&shifted[2*WIDTH-1:WIDTH-1]) || !(|shifted[2*WIDTH-1:WIDTH-1])) begin
      p = shifted[WIDTH-1:0];
    end else begin
      p = shifted[2*WIDTH-1] ? MAX_NEG : MAX_POS;
    end
  end

endmodule

// File: rtl/activation_backprop.sv
// Backward pass of the clamp-sigmoid neuron: computes delta once per sample, then
// streams dw[i] = delta * in[i] for every input through a valid/ready handshake.
module activation_backprop
  import nn_fixed_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int IDX_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic signed [WIDTH-1:0] target,
  input  logic signed [WIDTH-1:0] eta,
  output logic [IDX_W-1:0]        in_addr,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    dw_valid,
  input  logic                    dw_ready,
  output logic signed [WIDTH-1:0] dw_data,
  output logic [IDX_W-1:0]        dw_idx,
  output logic signed [WIDTH-1:0] delta,
  output logic                    done
);

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, target_q, target_d, eta_q, eta_d;
  logic signed [WIDTH-1:0] delta_q, delta_d, dw_data_q, dw_data_d;
  logic [IDX_W-1:0]        i_q, i_d;

  logic signed [WIDTH-1:0] err, mul_a, mul_b, mul_p;
  logic                    in_range, last_beat;

  assign err       = sat32({target_q[WIDTH-1], target_q} - {y_q[WIDTH-1], y_q});
  assign in_range  = !x_q[WIDTH-1] && (x_q <= ONE);
  assign last_beat = (i_q == IDX_W'(N_INPUTS - 1));

  // One multiplier serves both eta*err in CALC and delta*in_data in MUL.
  assign mul_a = (state_q == ST_CALC) ? eta_q : delta_q;
  assign mul_b = (state_q == ST_CALC) ? err   : in_data;

  fx_mul_sat u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      target_q  <= '0;
      eta_q     <= '0;
      delta_q   <= '0;
      dw_data_q <= '0;
      i_q       <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      target_q  <= target_d;
      eta_q     <= eta_d;
      delta_q   <= delta_d;
      dw_data_q <= dw_data_d;
      i_q       <= i_d;
    end
  end

  // NOTE: every comb output is defaulted first, so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_valid) state_d = ST_CALC;
      ST_CALC:  state_d = ST_FETCH;
      ST_FETCH: state_d = ST_MUL;
      ST_MUL:   state_d = ST_HOLD;
      ST_HOLD:  if (dw_ready) state_d = last_beat ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    target_d  = target_q;
    eta_d     = eta_q;
    delta_d   = delta_q;
    dw_data_d = dw_data_q;
    i_d       = i_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          x_d      = x;
          y_d      = y;
          target_d = target;
          eta_d    = eta;
          i_d      = '0;
        end
      end
      ST_CALC: delta_d   = in_range ? mul_p : '0;
      ST_MUL:  dw_data_d = mul_p;
      ST_HOLD: if (dw_ready && !last_beat) i_d = i_q + 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    start_ready = (state_q == ST_IDLE);
    dw_valid    = (state_q == ST_HOLD);
    done        = (state_q == ST_DONE);
  end

  assign in_addr = i_q;
  assign dw_idx  = i_q;
  assign dw_data = dw_data_q;
  assign delta   = delta_q;

endmodule
